// File: rtl/onehot32_encoder_stream_if.sv
// onehot32_encoder_stream_if: vector-in / index-out handshake bundle.
//   in_valid/in_ready/in_vec : request vector stream into the encoder
//   out_valid/out_ready      : index beat handshake out of the encoder
//   out_idx/out_last/out_none/out_count : beat payload and vector popcount
//   slave modport = encoder side, master modport = producer/consumer side
interface onehot32_encoder_stream_if #(
    parameter int N = 32,
    parameter int W = 5
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_none;
    logic [W:0]   out_count;

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none, out_count
    );

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none, out_count
    );
endinterface

// File: rtl/onehot32_encoder_stream.sv
// onehot32_encoder_stream: serialises an N-bit vector into ascending W-bit set-bit indices.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   s    : slave handshake bundle (vector in, index beats out with last/none/count)
module onehot32_encoder_stream #(
    parameter int N = 32,
    parameter int W = 5
) (
    input logic                        clk,
    input logic                        rst,
    onehot32_encoder_stream_if.slave   s
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W:0]   cnt_q, cnt_d;
    logic [W-1:0] idx;
    logic [W:0]   pop;
    logic         empty, single;

    // Downward scan so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pend_q[i]) idx = W'(i);
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++)
            pop = pop + (W+1)'(s.in_vec[i]);
    end

    assign empty  = pend_q == '0;
    // x & (x-1) clears the lowest set bit; zero result means at most one bit was set.
    assign single = !empty && ((pend_q & (pend_q - N'(1))) == '0);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && s.in_valid) begin
            pend_d  = s.in_vec;
            cnt_d   = pop;
            state_d = EMIT;
        end else if (state_q == EMIT && s.out_ready) begin
            pend_d  = pend_q & (pend_q - N'(1));
            state_d = (single || empty) ? IDLE : EMIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s.in_ready  = state_q == IDLE;
    assign s.out_valid = state_q == EMIT;
    assign s.out_idx   = idx;
    assign s.out_last  = s.out_valid && (single || empty);
    assign s.out_none  = s.out_valid && empty;
    assign s.out_count = cnt_q;
endmodule

// File: tb/tb_onehot32_encoder_stream.sv
// tb_onehot32_encoder_stream: directed self-checking bench for onehot32_encoder_stream.
module tb_onehot32_encoder_stream;
    logic clk = 0;
    logic rst = 1;
    int   n_chk = 0;
    int   n_fail = 0;

    onehot32_encoder_stream_if bus ();
    onehot32_encoder_stream dut (.clk(clk), .rst(rst), .s(bus));

    always #5 clk = ~clk;

    task automatic send(input logic [31:0] v);
        @(negedge clk);
        bus.in_valid = 1;
        bus.in_vec   = v;
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        bus.in_vec   = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset;
        bus.in_valid = 0;
        bus.in_vec = 0;
        bus.out_ready = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_chk++; if (bus.out_idx !== 5'd0) begin n_fail++; $display("FAIL reset_out_idx got %0d want 0", bus.out_idx); end
        n_chk++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
        n_chk++; if (bus.out_none !== 1'b0) begin n_fail++; $display("FAIL reset_out_none got %b want 0", bus.out_none); end
        n_chk++; if (bus.out_count !== 6'd0) begin n_fail++; $display("FAIL reset_out_count got %0d want 0", bus.out_count); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_sweep;
        bus.out_ready = 1;
        for (int k = 0; k < 32; k++) begin
            send(32'd1 << k);
            n_chk++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'(k) || bus.out_last !== 1'b1 || bus.out_none !== 1'b0 || bus.out_count !== 6'd1) begin
                n_fail++; $display("FAIL sweep_beat k=%0d got v=%b idx=%0d last=%b none=%b cnt=%0d want v=1 idx=%0d last=1 none=0 cnt=1", k, bus.out_valid, bus.out_idx, bus.out_last, bus.out_none, bus.out_count, k);
            end
            @(posedge clk);
            #1;
            n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL sweep_idle k=%0d got v=%b rdy=%b want v=0 rdy=1", k, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_multi;
        logic [4:0] exp_idx [4] = '{5'd0, 5'd2, 5'd8, 5'd31};
        bus.out_ready = 1;
        send(32'h8000_0105);
        for (int b = 0; b < 4; b++) begin
            n_chk++; if (bus.out_valid !== 1'b1 || bus.out_idx !== exp_idx[b] || bus.out_last !== (b == 3) || bus.out_none !== 1'b0 || bus.out_count !== 6'd4 || bus.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL multi_beat b=%0d got v=%b idx=%0d last=%b none=%b cnt=%0d rdy=%b want v=1 idx=%0d last=%b none=0 cnt=4 rdy=0", b, bus.out_valid, bus.out_idx, bus.out_last, bus.out_none, bus.out_count, bus.in_ready, exp_idx[b], b == 3);
            end
            @(posedge clk);
            #1;
        end
        n_chk++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL multi_idle got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_empty;
        bus.out_ready = 1;
        send(32'h0);
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_none !== 1'b1 || bus.out_last !== 1'b1 || bus.out_idx !== 5'd0 || bus.out_count !== 6'd0) begin
            n_fail++; $display("FAIL empty_beat got v=%b none=%b last=%b idx=%0d cnt=%0d want v=1 none=1 last=1 idx=0 cnt=0", bus.out_valid, bus.out_none, bus.out_last, bus.out_idx, bus.out_count);
        end
        @(posedge clk);
        #1;
        n_chk++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_none !== 1'b0) begin
            n_fail++; $display("FAIL empty_idle got rdy=%b v=%b none=%b want rdy=1 v=0 none=0", bus.in_ready, bus.out_valid, bus.out_none);
        end
    endtask

    task automatic test_backpressure;
        int  exp = 0;
        int  cyc = 0;
        bit  took;
        bus.out_ready = 0;
        send(32'hFFFF_FFFF);
        while (!(exp == 32 && !bus.out_valid) && cyc < 400) begin
            bus.in_valid = 0;
            if (bus.out_valid) begin
                n_chk++; if (exp > 31 || bus.out_idx !== 5'(exp) || bus.out_last !== (exp == 31) || bus.out_none !== 1'b0 || bus.out_count !== 6'd32 || bus.in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL bp_beat exp=%0d got idx=%0d last=%b none=%b cnt=%0d rdy=%b want idx=%0d last=%b none=0 cnt=32 rdy=0", exp, bus.out_idx, bus.out_last, bus.out_none, bus.out_count, bus.in_ready, exp, exp == 31);
                end
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_vec = 32'h0000_0001;
            end else begin
                n_chk++; n_fail++;
                $display("FAIL bp_gap got out_valid=0 with %0d beats done want 1", exp);
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            took = bus.out_valid && bus.out_ready;
            @(posedge clk);
            #1;
            if (took) exp++;
            cyc++;
        end
        bus.in_valid = 0;
        n_chk++; if (exp !== 32 || cyc >= 400) begin
            n_fail++; $display("FAIL bp_total got %0d beats in %0d cycles want 32 within 400", exp, cyc);
        end
        @(posedge clk);
        #1;
        n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_idle got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid;
        bus.out_ready = 1;
        send(32'h0000_00F0);
        n_chk++; if (bus.out_idx !== 5'd4 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rmid_first got idx=%0d v=%b want idx=4 v=1", bus.out_idx, bus.out_valid);
        end
        repeat (2) begin @(posedge clk); #1; end
        n_chk++; if (bus.out_idx !== 5'd6 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rmid_third got idx=%0d v=%b want idx=6 v=1", bus.out_idx, bus.out_valid);
        end
        #1;
        rst = 1;
        #1;
        n_chk++; if (bus.out_valid !== 1'b0 || bus.out_count !== 6'd0) begin
            n_fail++; $display("FAIL rmid_async got v=%b cnt=%0d want v=0 cnt=0", bus.out_valid, bus.out_count);
        end
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_idx !== 5'd0) begin
                n_fail++; $display("FAIL rmid_after c=%0d got v=%b rdy=%b idx=%0d want v=0 rdy=1 idx=0", c, bus.out_valid, bus.in_ready, bus.out_idx);
            end
        end
    endtask

    initial begin
        test_reset;
        test_sweep;
        test_multi;
        test_empty;
        test_backpressure;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/onehot32_encoder_stream.md
Name: onehot32_encoder_stream

Overview:
Inverse companion to the 5-to-32 decoder. It accepts a 32-bit request/one-hot vector over a valid/ready handshake and serialises it into a stream of 5-bit indices, one per set bit, in ascending order. Each index is presented on a valid/ready output handshake with last and empty flags. It sits between a decoded select bus and any consumer that needs binary addresses back, such as an arbiter, interrupt controller or register-file write-back.

Parameters:
N, 32, input vector width; must be a power of two.
W, 5, index width; must equal log2(N).

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  in_vec is valid this cycle
in_ready  out  1  block can accept a vector; high iff state==IDLE
in_vec  in  N  vector to encode
out_valid  out  1  out_idx/out_last/out_none are valid
out_ready  in  1  consumer accepts the current beat
out_idx  out  W  index of the lowest remaining set bit
out_last  out  1  current beat is the final beat for this vector
out_none  out  1  accepted vector was all-zero; single beat with out_idx=0
out_count  out  W+1  popcount of the accepted vector (0..N), registered at accept

Behaviour:
- Reset (asynchronous, any time):
  - state=IDLE, pending=0.
  - out_valid=0, out_idx=0, out_last=0, out_none=0, out_count=0.
  - in_ready=1 once state is IDLE.
  - Any transfer in progress is discarded; no partial beat is emitted after reset.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept on the clk edge where in_valid&&in_ready: pending<=in_vec, out_count<=popcount(in_vec), state<=EMIT.
  - in_vec is not sampled when in_valid=0.
- EMIT:
  - in_ready=0; in_valid is ignored and causes no back-pressure violation.
  - out_valid=1 from the first cycle after accept, so accept-to-first-beat latency is 1 cycle.
  - out_idx = index of the least-significant 1 in pending.
  - out_last = pending has exactly one bit set.
  - If pending==0 (empty vector): out_none=1, out_last=1, out_idx=0, out_count=0.
- Beat transfer: on an edge with out_valid&&out_ready, clear that bit in pending.
  - If out_last: state<=IDLE, so in_ready=1 in the next cycle.
  - Otherwise stay in EMIT; the next index is valid in the next cycle. Back-to-back beats run at 1 per cycle when out_ready is held high.
- Stall: while out_valid&&!out_ready, out_idx, out_last, out_none and out_count hold stable.
- Vector turnaround: at least one IDLE cycle separates vectors, so the minimum time per vector is popcount+1 cycles (2 cycles for an empty vector).
- Index order is strictly ascending. The full-ones vector yields 32 beats, 0..31, with out_last only on idx 31.
- Width rules:
  - out_count is W+1 bits so a value of 32 is representable.
  - out_idx never exceeds N-1.
- All outputs are registered or derived only from state/pending; there is no combinational path from in_* to out_*.

Test Plan:
- Reset mid-EMIT: accept 32'h0000_00F0, then assert rst after 2 beats -> out_valid=0 asynchronously, state returns to IDLE, in_ready=1 after release, no further beats.
- Full sweep: accept each one-hot 1<<k for k=0..31, out_ready=1 -> one beat per vector with out_idx=k, out_last=1, out_none=0, out_count=1 (round-trip check against decoder5to32 with enable=1).
- Multi-bit: in_vec=32'h8000_0105, out_ready=1 -> beats idx 0,2,8,31 on consecutive cycles, out_last only on 31, out_count=4, in_ready=1 on the cycle after the last beat.
- Empty vector: in_vec=0 -> single beat, out_none=1, out_last=1, out_idx=0, out_count=0, then IDLE.
- Back-pressure: in_vec=32'hFFFF_FFFF with out_ready toggled randomly -> exactly 32 beats, 0..31 ascending, outputs stable during stalls, out_count=32, in_valid pulses during EMIT ignored.
